// File: rtl/banco_contadores_actividad_if.sv
// Control, monitored-bus and read-port signals of the activity counter bank.
// master drives the buses and read requests; slave is the counter bank itself.
interface banco_contadores_actividad_if #(
    parameter int unsigned NUM_CANALES = 3,
    parameter int unsigned ANCHO_SENAL = 8,
    parameter int unsigned ANCHO_CONT  = 32,
    parameter int unsigned ANCHO_DIR   = 2
);
    logic                               habilitar;
    logic [NUM_CANALES*ANCHO_SENAL-1:0] senales;
    logic                               borrar;
    logic                               leer;
    logic [ANCHO_DIR-1:0]               dir;
    logic [ANCHO_CONT-1:0]              dato;
    logic                               dato_valido;
    logic [NUM_CANALES-1:0]             saturado;

    modport master (
        output habilitar, senales, borrar, leer, dir,
        input  dato, dato_valido, saturado
    );

    modport slave (
        input  habilitar, senales, borrar, leer, dir,
        output dato, dato_valido, saturado
    );
endinterface

// File: rtl/banco_contadores_actividad.sv
// Per-channel saturating bit-toggle counters plus a shared cycle counter,
// with a registered read port addressed by dir.
module banco_contadores_actividad #(
    parameter int unsigned NUM_CANALES = 3,
    parameter int unsigned ANCHO_SENAL = 8,
    parameter int unsigned ANCHO_CONT  = 32,
    parameter int unsigned ANCHO_DIR   = 2
) (
    input logic                          clk,
    input logic                          reset,
    banco_contadores_actividad_if.slave  bus
);
    localparam int unsigned ANCHO_POP  = $clog2(ANCHO_SENAL + 1);
    localparam int unsigned ANCHO_SUMA = ANCHO_CONT + 1;
    localparam logic [ANCHO_CONT-1:0] CONT_MAX = '1;

    logic [ANCHO_SENAL-1:0] previo_q [NUM_CANALES];
    logic [ANCHO_CONT-1:0]  cont_q   [NUM_CANALES];
    logic [ANCHO_CONT-1:0]  cont_d   [NUM_CANALES];
    logic [ANCHO_POP-1:0]   inc      [NUM_CANALES];
    logic [ANCHO_SUMA-1:0]  suma     [NUM_CANALES];
    logic [ANCHO_CONT-1:0]  ciclos_q, ciclos_d;
    logic [NUM_CANALES-1:0] saturado_q, saturado_d;
    logic [ANCHO_CONT-1:0]  dato_q, lectura;
    logic                   dato_valido_q;
    logic                   cebado_q;
    logic                   contar;

    // Toggle count per channel; one extra sum bit exposes overflow past CONT_MAX.
    always_comb begin
        for (int k = 0; k < NUM_CANALES; k++) begin
            inc[k] = '0;
            for (int b = 0; b < ANCHO_SENAL; b++) begin
                inc[k] = inc[k] + ANCHO_POP'(bus.senales[k*ANCHO_SENAL + b] ^ previo_q[k][b]);
            end
            suma[k] = {1'b0, cont_q[k]} + ANCHO_SUMA'(inc[k]);
        end
    end

    always_comb begin
        contar     = bus.habilitar && cebado_q && !bus.borrar;
        ciclos_d   = ciclos_q;
        saturado_d = saturado_q;
        for (int k = 0; k < NUM_CANALES; k++) begin
            cont_d[k] = cont_q[k];
        end
        if (bus.borrar) begin
            ciclos_d   = '0;
            saturado_d = '0;
            for (int k = 0; k < NUM_CANALES; k++) begin
                cont_d[k] = '0;
            end
        end else if (contar) begin
            for (int k = 0; k < NUM_CANALES; k++) begin
                if (suma[k] >= {1'b0, CONT_MAX}) begin
                    cont_d[k]     = CONT_MAX;
                    saturado_d[k] = 1'b1;
                end else begin
                    cont_d[k] = suma[k][ANCHO_CONT-1:0];
                end
            end
            if (ciclos_q != CONT_MAX) begin
                ciclos_d = ciclos_q + 1'b1;
            end
        end
    end

    // Read mux sees pre-edge state; unmapped addresses return zero.
    always_comb begin
        lectura = '0;
        for (int k = 0; k < NUM_CANALES; k++) begin
            if (bus.dir == ANCHO_DIR'(k)) begin
                lectura = cont_q[k];
            end
        end
        if (bus.dir == ANCHO_DIR'(NUM_CANALES)) begin
            lectura = ciclos_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_CANALES; k++) begin
                previo_q[k] <= '0;
                cont_q[k]   <= '0;
            end
            ciclos_q      <= '0;
            saturado_q    <= '0;
            cebado_q      <= 1'b0;
            dato_q        <= '0;
            dato_valido_q <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_CANALES; k++) begin
                previo_q[k] <= bus.senales[k*ANCHO_SENAL +: ANCHO_SENAL];
                cont_q[k]   <= cont_d[k];
            end
            ciclos_q      <= ciclos_d;
            saturado_q    <= saturado_d;
            cebado_q      <= !bus.borrar;
            dato_valido_q <= bus.leer;
            if (bus.leer) begin
                dato_q <= lectura;
            end
        end
    end

    assign bus.dato        = dato_q;
    assign bus.dato_valido = dato_valido_q;
    assign bus.saturado    = saturado_q;
endmodule

// File: tb/tb_banco_contadores_actividad.sv
// Bench for banco_contadores_actividad: a 32-bit/2-bit-address and an 8-bit/3-bit-address
// instance share stimulus and are checked against a behavioural model every cycle.
module tb_banco_contadores_actividad;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        habilitar = 1'b0;
    logic [23:0] senales = '0;
    logic        borrar = 1'b0;
    logic        leer = 1'b0;
    logic [2:0]  dir = '0;

    int checks = 0;
    int failures = 0;

    banco_contadores_actividad_if #(
        .NUM_CANALES(3), .ANCHO_SENAL(8), .ANCHO_CONT(32), .ANCHO_DIR(2)
    ) bus_a ();
    banco_contadores_actividad_if #(
        .NUM_CANALES(3), .ANCHO_SENAL(8), .ANCHO_CONT(8), .ANCHO_DIR(3)
    ) bus_b ();

    assign bus_a.habilitar = habilitar;
    assign bus_a.senales   = senales;
    assign bus_a.borrar    = borrar;
    assign bus_a.leer      = leer;
    assign bus_a.dir       = dir[1:0];
    assign bus_b.habilitar = habilitar;
    assign bus_b.senales   = senales;
    assign bus_b.borrar    = borrar;
    assign bus_b.leer      = leer;
    assign bus_b.dir       = dir;

    banco_contadores_actividad #(
        .NUM_CANALES(3), .ANCHO_SENAL(8), .ANCHO_CONT(32), .ANCHO_DIR(2)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );
    banco_contadores_actividad #(
        .NUM_CANALES(3), .ANCHO_SENAL(8), .ANCHO_CONT(8), .ANCHO_DIR(3)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    // Behavioural model: index 0 = dut_a, 1 = dut_b.
    longint unsigned cont_m [2][3];
    longint unsigned cic_m  [2];
    longint unsigned dato_m [2];
    bit [2:0]        sat_m  [2];
    bit              val_m  [2];
    bit [7:0]        previo_m [3];
    bit              cebado_m = 1'b0;

    function automatic longint unsigned max_m(input int i);
        return (i == 0) ? 64'hFFFF_FFFF : 64'd255;
    endfunction

    task automatic chk(input string nombre, input longint unsigned act,
                       input longint unsigned esp);
        checks++;
        if (act != esp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nombre, act, esp, $time);
        end
    endtask

    task automatic modelo_reset();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 3; k++) cont_m[i][k] = 0;
            cic_m[i] = 0; dato_m[i] = 0; sat_m[i] = '0; val_m[i] = 1'b0;
        end
        for (int k = 0; k < 3; k++) previo_m[k] = '0;
        cebado_m = 1'b0;
    endtask

    task automatic modelo_paso();
        for (int i = 0; i < 2; i++) begin
            int d;
            d = (i == 0) ? int'(dir[1:0]) : int'(dir);
            val_m[i] = leer;
            if (leer) dato_m[i] = (d < 3) ? cont_m[i][d] : ((d == 3) ? cic_m[i] : 0);
            if (borrar) begin
                for (int k = 0; k < 3; k++) cont_m[i][k] = 0;
                cic_m[i] = 0;
                sat_m[i] = '0;
            end else if (habilitar && cebado_m) begin
                for (int k = 0; k < 3; k++) begin
                    longint unsigned s;
                    s = cont_m[i][k] + longint'($countones(senales[k*8 +: 8] ^ previo_m[k]));
                    if (s >= max_m(i)) begin
                        cont_m[i][k] = max_m(i);
                        sat_m[i][k]  = 1'b1;
                    end else begin
                        cont_m[i][k] = s;
                    end
                end
                if (cic_m[i] < max_m(i)) cic_m[i]++;
            end
        end
        cebado_m = !borrar;
        for (int k = 0; k < 3; k++) previo_m[k] = senales[k*8 +: 8];
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) modelo_reset();
        else modelo_paso();
        #1;
        chk("dato_a", longint'(bus_a.dato), dato_m[0]);
        chk("valido_a", longint'(bus_a.dato_valido), longint'(val_m[0]));
        chk("saturado_a", longint'(bus_a.saturado), longint'(sat_m[0]));
        chk("dato_b", longint'(bus_b.dato), dato_m[1]);
        chk("valido_b", longint'(bus_b.dato_valido), longint'(val_m[1]));
        chk("saturado_b", longint'(bus_b.saturado), longint'(sat_m[1]));
    end

    task automatic paso();
        @(posedge clk);
        #2;
    endtask

    task automatic reiniciar(input logic [23:0] s);
        reset = 1'b1; habilitar = 1'b0; borrar = 1'b0; leer = 1'b0; senales = s;
        paso();
        reset = 1'b0;
    endtask

    task automatic leer_dir(input logic [2:0] d);
        leer = 1'b1; dir = d;
        paso();
        leer = 1'b0;
    endtask

    initial begin
        // Two toggles of 8 bits each on channel 0.
        reiniciar(24'h000000);
        habilitar = 1'b1;
        paso();
        senales[7:0] = 8'hFF; paso();
        senales[7:0] = 8'h00; paso();
        habilitar = 1'b0;
        leer_dir(3'd0);
        chk("t1_cont0_a", longint'(bus_a.dato), 16);
        chk("t1_cont0_b", longint'(bus_b.dato), 16);
        chk("t1_valido", longint'(bus_a.dato_valido), 1);
        leer_dir(3'd3);
        chk("t1_ciclos_a", longint'(bus_a.dato), 2);
        chk("t1_ciclos_b", longint'(bus_b.dato), 2);
        paso();
        chk("t1_valido_pulso", longint'(bus_a.dato_valido), 0);

        // Constant channel 1: no toggles, baseline edge not counted.
        reiniciar(24'h00FF00);
        habilitar = 1'b1;
        repeat (10) paso();
        habilitar = 1'b0;
        leer_dir(3'd1);
        chk("t2_cont1", longint'(bus_a.dato), 0);
        leer_dir(3'd3);
        chk("t2_ciclos", longint'(bus_a.dato), 9);
        chk("t2_saturado", longint'(bus_a.saturado), 0);

        // Toggle while disabled is absorbed by the baseline.
        reiniciar(24'h0F0000);
        paso();
        senales = 24'hF00000; paso();
        habilitar = 1'b1;
        repeat (5) paso();
        habilitar = 1'b0;
        leer_dir(3'd2);
        chk("t3_cont2", longint'(bus_a.dato), 0);
        leer_dir(3'd3);
        chk("t3_ciclos", longint'(bus_a.dato), 5);

        // 40 full toggles: 320 on the wide bank, saturates at 255 on the narrow one.
        reiniciar(24'h000000);
        habilitar = 1'b1;
        paso();
        for (int i = 0; i < 40; i++) begin
            senales[7:0] = ~senales[7:0];
            paso();
        end
        habilitar = 1'b0;
        leer_dir(3'd0);
        chk("t4_cont0_a", longint'(bus_a.dato), 320);
        chk("t4_cont0_b", longint'(bus_b.dato), 255);
        chk("t4_sat_a", longint'(bus_a.saturado), 0);
        chk("t4_sat_b", longint'(bus_b.saturado), 1);

        // Read and clear together, then baseline edge after the clear.
        habilitar = 1'b1; leer = 1'b1; dir = 3'd0; borrar = 1'b1;
        senales[7:0] = ~senales[7:0];
        paso();
        borrar = 1'b0;
        chk("t5_dato_old_a", longint'(bus_a.dato), 320);
        chk("t5_dato_old_b", longint'(bus_b.dato), 255);
        chk("t5_sat_clr_b", longint'(bus_b.saturado), 0);
        senales[7:0] = ~senales[7:0]; paso();
        chk("t5_after_clr", longint'(bus_b.dato), 0);
        senales[7:0] = ~senales[7:0]; paso();
        chk("t5_first_toggle", longint'(bus_b.dato), 0);
        paso();
        chk("t5_second_toggle_a", longint'(bus_a.dato), 8);
        chk("t5_second_toggle_b", longint'(bus_b.dato), 8);
        leer = 1'b0; habilitar = 1'b0;

        // Accumulate 12, read unmapped address, then reset with a read pending.
        reiniciar(24'h000000);
        habilitar = 1'b1;
        paso();
        senales[7:0] = 8'h0F; paso();
        senales[7:0] = 8'h00; paso();
        senales[7:0] = 8'h0F; paso();
        habilitar = 1'b0;
        leer_dir(3'd4);
        chk("t6_unmapped_b", longint'(bus_b.dato), 0);
        chk("t6_alias_a", longint'(bus_a.dato), 12);
        leer_dir(3'd0);
        chk("t6_cont0", longint'(bus_b.dato), 12);
        #1 reset = 1'b1;
        #2;
        chk("t6_reset_dato", longint'(bus_a.dato), 0);
        chk("t6_reset_valido", longint'(bus_a.dato_valido), 0);
        paso();
        reset = 1'b0;
        leer_dir(3'd0);
        chk("t6_post_reset", longint'(bus_a.dato), 0);
        leer_dir(3'd7);
        chk("t6_dir7_b", longint'(bus_b.dato), 0);

        // Randomised traffic with occasional clears and resets.
        for (int n = 0; n < 3000; n++) begin
            senales   = 24'($urandom);
            habilitar = ($urandom_range(0, 9) < 8);
            borrar    = ($urandom_range(0, 99) < 2);
            leer      = $urandom_range(0, 1) == 1;
            dir       = 3'($urandom_range(0, 7));
            if (n % 8 < 3) senales = {senales[23:8], previo_m[0]};
            if ($urandom_range(0, 499) == 0) reset = 1'b1;
            paso();
            reset = 1'b0;
        end
        leer = 1'b0; borrar = 1'b0; habilitar = 1'b0;
        paso();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
